mul_share_arbiter: RTL and testbench

- Time-shares one combinational WIDTH x WIDTH Dadda multiplier datapath between NUM_REQ requesters.
- Per-requester valid/ready handshake with round-robin arbitration.
- Registers the operands of the granted requester and drives the multiplier from those registers.
- Captures the product and returns it on a single response channel tagged with the requester ID; the response channel supports backpressure.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/mul_share_arbiter.sv | 112 +++++++++++
 tb/tb_mul_share_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mul_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    typedef logic [2*DEF_WIDTH-1:0] prod_t;

    // Round-robin successor of idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_grant
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDW'((32'(ptr) + off) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Time-shares one external combinational multiplier between NUM_REQ requesters,
// returning tagged products on a single backpressured response channel.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_in1,
    output logic [WIDTH-1:0]         mul_in2,
    input  logic [2*WIDTH-1:0]       mul_out,
    input  logic                     mul_ovf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_prod,
    output logic                     rsp_ovf
);

    state_t             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               any_grant;
    logic               arb_open;
    logic               take;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [IDW-1:0]     ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A new request may be accepted while idle, or in the same cycle the
    // pending response is consumed.
    assign arb_open  = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
    assign take      = arb_open && any_grant;
    assign req_ready = arb_open ? grant : '0;
    assign ptr_next  = IDW'(wrap_inc(32'(grant_idx), NUM_REQ));

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            id_q      <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_grant) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_prod  <= mul_out;
                    rsp_ovf   <= mul_ovf;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= any_grant ? StExec : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (take) begin
                mul_in1 <= sel_a;
                mul_in2 <= sel_b;
                id_q    <= grant_idx;
                ptr_q   <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter.
module tb_mul_share_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     mul_in1;
    logic [W-1:0]     mul_in2;
    logic [2*W-1:0]   mul_out;
    logic             mul_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_prod;
    logic             rsp_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Multiplier stand-in; the overflow flag is an arbitrary product threshold.
    assign mul_out = 8'(mul_in1) * 8'(mul_in2);
    assign mul_ovf = (mul_out > 8'd200);

    mul_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .IDW     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_in1   (mul_in1),
        .mul_in2   (mul_in2),
        .mul_out   (mul_out),
        .mul_ovf   (mul_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_ovf   (rsp_ovf)
    );

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]      = 1'b1;
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_prod !== 8'd0 || rsp_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp got v=%b id=%0d p=%0d o=%b exp 0/0/0/0",
                     rsp_valid, rsp_id, rsp_prod, rsp_ovf);
        end
        checks++;
        if (mul_in1 !== 4'd0 || mul_in2 !== 4'd0) begin
            failures++;
            $display("FAIL reset_mul got in1=%0d in2=%0d exp 0/0", mul_in1, mul_in2);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 4'd13, 4'd11);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || mul_in1 !== 4'd13 || mul_in2 !== 4'd11) begin
            failures++;
            $display("FAIL single_exec got v=%b in1=%0d in2=%0d exp 0/13/11",
                     rsp_valid, mul_in1, mul_in2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_prod !== 8'd143 || rsp_ovf !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp got v=%b id=%0d p=%0d o=%b exp 1/2/143/0",
                     rsp_valid, rsp_id, rsp_prod, rsp_ovf);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drop got v=%b exp 0", rsp_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rdy;
        int         id;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 4'd15);
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_rdy = (k % 2 == 0) ? 4'(1 << ((k / 2) % N)) : 4'd0;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL fair_grant k=%0d got=%b exp=%b", k, req_ready, exp_rdy);
            end
            if (k >= 2 && k % 2 == 0) begin
                id = (k / 2 - 1) % N;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_prod !== 8'((id + 1) * 15)) begin
                    failures++;
                    $display("FAIL fair_rsp k=%0d got v=%b id=%0d p=%0d exp 1/%0d/%0d",
                             k, rsp_valid, rsp_id, rsp_prod, id, (id + 1) * 15);
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fair_idle k=%0d got v=%b exp 0", k, rsp_valid);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 4'd15, 4'd15);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        set_req(1, 4'd2, 4'd3);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL bp_exec_ready got=%b exp=0000", req_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_prod !== 8'd225 || rsp_id !== 2'd0 ||
                rsp_ovf !== 1'b1 || req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold k=%0d got v=%b p=%0d id=%0d o=%b rdy=%b exp 1/225/0/1/0000",
                         k, rsp_valid, rsp_prod, rsp_id, rsp_ovf, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010 || rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got rdy=%b v=%b exp 0010/1", req_ready, rsp_valid);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || mul_in1 !== 4'd2 || mul_in2 !== 4'd3) begin
            failures++;
            $display("FAIL bp_next_exec got v=%b in1=%0d in2=%0d exp 0/2/3",
                     rsp_valid, mul_in1, mul_in2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_prod !== 8'd6 || rsp_ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_rsp got v=%b id=%0d p=%0d o=%b exp 1/1/6/0",
                     rsp_valid, rsp_id, rsp_prod, rsp_ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1'b1;
        set_req(3, 4'd5, 4'd5);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_first got=%b exp=1000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        set_req(0, 4'd1, 4'd2);
        set_req(3, 4'd3, 4'd3);
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_id !== 2'd3 || rsp_prod !== 8'd25) begin
            failures++;
            $display("FAIL wrap_second got rdy=%b id=%0d p=%0d exp 0001/3/25",
                     req_ready, rsp_id, rsp_prod);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b1000 || rsp_id !== 2'd0 || rsp_prod !== 8'd2) begin
            failures++;
            $display("FAIL wrap_third got rdy=%b id=%0d p=%0d exp 1000/0/2",
                     req_ready, rsp_id, rsp_prod);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_edge_operands();
        logic [3:0] ea [3];
        logic [3:0] eb [3];
        logic [7:0] ep [3];
        ea = '{4'd0, 4'd15, 4'd1};
        eb = '{4'd15, 4'd1, 4'd1};
        ep = '{8'd0, 8'd15, 8'd1};
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(1, ea[k], eb[k]);
            #1;
            checks++;
            if (req_ready !== 4'b0010) begin
                failures++;
                $display("FAIL edge_grant k=%0d got=%b exp=0010", k, req_ready);
            end
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_prod !== ep[k] || rsp_id !== 2'd1) begin
                failures++;
                $display("FAIL edge_prod k=%0d got v=%b p=%0d id=%0d exp 1/%0d/1",
                         k, rsp_valid, rsp_prod, rsp_id, ep[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        rsp_ready = 1'b1;
        set_req(2, 4'd7, 4'd9);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL midrst_grant got=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || mul_in1 !== 4'd0 || mul_in2 !== 4'd0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_state got v=%b in1=%0d in2=%0d rdy=%b exp 0/0/0/0000",
                     rsp_valid, mul_in1, mul_in2, req_ready);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_stale k=%0d got v=%b exp 0", k, rsp_valid);
            end
            @(negedge clk);
        end
        set_req(1, 4'd2, 4'd2);
        set_req(3, 4'd4, 4'd4);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL midrst_regrant got=%b exp=0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random();
        int         ptr;
        bit         has_op;
        int         resp_at;
        int         e_id;
        int         e_prod;
        bit         e_ovf;
        bit         exp_rv;
        bit         allowed;
        int         g;
        int         idx;
        logic [3:0] done;
        logic [3:0] exp_rdy;
        do_reset();
        ptr    = 0;
        has_op = 1'b0;
        resp_at = 0;
        e_id   = 0;
        e_prod = 0;
        e_ovf  = 1'b0;
        done   = '0;
        for (int s = 0; s < 300; s++) begin
            rsp_ready = 1'($urandom % 2);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && done[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom % 3 == 0))
                    set_req(i, 4'($urandom), 4'($urandom));
            end
            done = '0;
            #1;
            exp_rv = has_op && (s >= resp_at);
            checks++;
            if (rsp_valid !== exp_rv) begin
                failures++;
                $display("FAIL rand_valid s=%0d got=%b exp=%b", s, rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rsp_id !== 2'(e_id) || rsp_prod !== 8'(e_prod) || rsp_ovf !== e_ovf) begin
                    failures++;
                    $display("FAIL rand_rsp s=%0d got id=%0d p=%0d o=%b exp %0d/%0d/%b",
                             s, rsp_id, rsp_prod, rsp_ovf, e_id, e_prod, e_ovf);
                end
            end
            allowed = !has_op || (exp_rv && rsp_ready);
            g = -1;
            if (allowed) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'd0;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_ready s=%0d got=%b exp=%b", s, req_ready, exp_rdy);
            end
            if (exp_rv && rsp_ready) has_op = 1'b0;
            if (g >= 0) begin
                has_op  = 1'b1;
                resp_at = s + 2;
                e_id    = g;
                e_prod  = int'(req_a[g*W +: W]) * int'(req_b[g*W +: W]);
                e_ovf   = (e_prod > 200);
                ptr     = (g + 1) % N;
                done[g] = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_edge_operands();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
